// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, FSM state type and datapath mux encodings for the multi-cycle RV32I+F control unit.
package mc_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFLoad  = 7'b0000111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFStore = 7'b0100111;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBeq    = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpFp     = 7'b1010011;

  typedef enum logic [4:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecuteR, StExecuteI,
    StAluWb, StBeq, StJal, StJalrJ, StJalrLnk, StLui, StFpExec, StFpWb, StIllegal
  } state_t;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResFpu       = 2'b11;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;
  localparam logic [1:0] AluFp     = 2'b11;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

endpackage

// File: rtl/imm_src_dec.sv
// Combinational immediate-format select from the instruction opcode.
module imm_src_dec import mc_ctrl_pkg::*; (
  input  logic [6:0] op,
  output logic [2:0] immSrc
);

  always_comb begin
    immSrc = ImmI;
    case (op)
      OpStore, OpFStore: immSrc = ImmS;
      OpBeq:             immSrc = ImmB;
      OpJal:             immSrc = ImmJ;
      OpLui:             immSrc = ImmU;
      default:           immSrc = ImmI;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multi-cycle control FSM with memory/FPU handshakes, FPU timeout trap and retire counter.
module multicycle_ctrl import mc_ctrl_pkg::*; #(
  parameter bit          FP_EN      = 1'b1,
  parameter int unsigned FP_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             fpu_done,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             FRegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             fpu_start,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned   WaitW    = $clog2(FP_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(FP_TIMEOUT - 1);

  state_t             stateQ, stateD;
  logic [WaitW-1:0]   waitCntQ, waitCntD;
  logic [CNT_W-1:0]   instretQ;
  logic               isLoad;

  assign isLoad  = (op == OpLoad) || (op == OpFLoad);
  assign instret = instretQ;

  imm_src_dec uImmSrcDec (
    .op     (op),
    .immSrc (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateQ   <= StFetch;
      waitCntQ <= '0;
      instretQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      if (stateQ != StFetch && stateD == StFetch) instretQ <= instretQ + CNT_W'(1);
    end
  end

  always_comb begin
    stateD    = stateQ;
    waitCntD  = '0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    FRegWrite = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRd2;
    ALUOp     = AluAdd;
    fpu_start = 1'b0;
    illegal   = 1'b0;

    unique case (stateQ)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        stateD    = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpLoad, OpStore:   stateD = StMemAdr;
          OpFLoad, OpFStore: stateD = FP_EN ? StMemAdr : StIllegal;
          OpRType:           stateD = StExecuteR;
          OpIAlu:            stateD = StExecuteI;
          OpBeq:             stateD = StBeq;
          OpJal:             stateD = StJal;
          OpJalr:            stateD = StJalrJ;
          OpLui:             stateD = StLui;
          OpFp:              stateD = FP_EN ? StFpExec : StIllegal;
          default:           stateD = StIllegal;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        stateD  = isLoad ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        stateD = mem_ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = (op == OpLoad);
        FRegWrite = (op == OpFLoad);
        stateD    = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        stateD   = mem_ready ? StFetch : StMemWrite;
      end
      StExecuteR: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBRd2;
        ALUOp   = AluFunct;
        stateD  = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        ALUOp   = AluFunct;
        stateD  = StAluWb;
      end
      StAluWb: begin
        RegWrite  = 1'b1;
        ResultSrc = ResAluOut;
        stateD    = StFetch;
      end
      StBeq: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBRd2;
        ALUOp   = AluBranch;
        Branch  = 1'b1;
        stateD  = StFetch;
      end
      StJal: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluOut;
        PCUpdate  = 1'b1;
        stateD    = StAluWb;
      end
      StJalrJ: begin
        ALUSrcA   = SrcARd1;
        ALUSrcB   = SrcBImm;
        ResultSrc = ResAluResult;
        PCUpdate  = 1'b1;
        stateD    = StJalrLnk;
      end
      StJalrLnk: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        RegWrite  = 1'b1;
        stateD    = StFetch;
      end
      StLui: begin
        ALUSrcA = SrcAZero;
        ALUSrcB = SrcBImm;
        stateD  = StAluWb;
      end
      StFpExec: begin
        // Counter is zero only on the entry cycle, which doubles as the start pulse.
        ALUOp     = AluFp;
        fpu_start = (waitCntQ == '0);
        waitCntD  = waitCntQ + WaitW'(1);
        if (fpu_done)                    stateD = StFpWb;
        else if (waitCntQ == WaitLast)   stateD = StIllegal;
      end
      StFpWb: begin
        ResultSrc = ResFpu;
        FRegWrite = 1'b1;
        stateD    = StFetch;
      end
      StIllegal: begin
        illegal = 1'b1;
        stateD  = StIllegal;
      end
      default: stateD = StIllegal;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level randomized bench: per-instruction step sequences checked cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 4;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpFlw = 7'b0000111;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpFsw = 7'b0100111;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBq  = 7'b1100011;
  localparam logic [6:0] OpJl  = 7'b1101111;
  localparam logic [6:0] OpJr  = 7'b1100111;
  localparam logic [6:0] OpLu  = 7'b0110111;
  localparam logic [6:0] OpF   = 7'b1010011;

  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRead = 3, SMemWb = 4, SMemWrite = 5;
  localparam int SExecR = 6, SExecI = 7, SAluWb = 8, SBeq = 9, SJal = 10, SJalrJ = 11;
  localparam int SJalrLnk = 12, SLui = 13, SFpExec = 14, SFpWb = 15, SIllegal = 16;

  typedef struct packed {
    logic       pcUpdate, branch, adrSrc, memWrite, irWrite, regWrite, fRegWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
    logic       fpuStart, illegal;
  } outs_t;

  logic clk = 1'b0;
  logic resetN, memReady, fpuDone;
  logic [6:0] op, opB;

  logic aPc, aBr, aAdr, aMw, aIr, aRw, aFrw, aStart, aIll;
  logic [1:0] aRes, aSa, aSb, aAop;
  logic [2:0] aImm;
  logic [CntW-1:0] aInstret;
  logic bPc, bBr, bAdr, bMw, bIr, bRw, bFrw, bStart, bIll;
  logic [1:0] bRes, bSa, bSb, bAop;
  logic [2:0] bImm;
  logic [31:0] bInstret;
  outs_t obsA, obsB;

  int checks = 0, errors = 0, retired = 0, bCycle = 0;
  bit bActive = 1'b0, trapped = 1'b0;

  assign obsA = {aPc, aBr, aAdr, aMw, aIr, aRw, aFrw, aRes, aSa, aSb, aAop, aStart, aIll};
  assign obsB = {bPc, bBr, bAdr, bMw, bIr, bRw, bFrw, bRes, bSa, bSb, bAop, bStart, bIll};

  always #5 clk = ~clk;

  multicycle_ctrl #(.FP_EN(1'b1), .FP_TIMEOUT(Timeout), .CNT_W(CntW)) dutA (
    .clk(clk), .reset_n(resetN), .op(op), .mem_ready(memReady), .fpu_done(fpuDone),
    .PCUpdate(aPc), .Branch(aBr), .AdrSrc(aAdr), .MemWrite(aMw), .IRWrite(aIr),
    .RegWrite(aRw), .FRegWrite(aFrw), .ResultSrc(aRes), .ALUSrcA(aSa), .ALUSrcB(aSb),
    .ALUOp(aAop), .ImmSrc(aImm), .fpu_start(aStart), .illegal(aIll), .instret(aInstret)
  );

  multicycle_ctrl #(.FP_EN(1'b0), .FP_TIMEOUT(64), .CNT_W(32)) dutB (
    .clk(clk), .reset_n(resetN), .op(opB), .mem_ready(memReady), .fpu_done(fpuDone),
    .PCUpdate(bPc), .Branch(bBr), .AdrSrc(bAdr), .MemWrite(bMw), .IRWrite(bIr),
    .RegWrite(bRw), .FRegWrite(bFrw), .ResultSrc(bRes), .ALUSrcA(bSa), .ALUSrcB(bSb),
    .ALUOp(bAop), .ImmSrc(bImm), .fpu_start(bStart), .illegal(bIll), .instret(bInstret)
  );

  function automatic outs_t expOut(input int st, input logic [6:0] o, input logic mr,
                                   input logic first);
    outs_t e;
    e = '0;
    case (st)
      SFetch:    begin e.aluSrcB = 2'b10; e.resultSrc = 2'b10; e.irWrite = mr; e.pcUpdate = mr; end
      SDecode:   begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; end
      SMemAdr:   begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; end
      SMemRead:  e.adrSrc = 1'b1;
      SMemWb:    begin e.resultSrc = 2'b01; e.regWrite = (o == OpLw); e.fRegWrite = (o == OpFlw); end
      SMemWrite: begin e.adrSrc = 1'b1; e.memWrite = 1'b1; end
      SExecR:    begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b00; e.aluOp = 2'b10; end
      SExecI:    begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluOp = 2'b10; end
      SAluWb:    begin e.regWrite = 1'b1; e.resultSrc = 2'b00; end
      SBeq:      begin e.aluSrcA = 2'b10; e.aluOp = 2'b01; e.branch = 1'b1; end
      SJal:      begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.pcUpdate = 1'b1; end
      SJalrJ:    begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.resultSrc = 2'b10; e.pcUpdate = 1'b1; end
      SJalrLnk:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; e.regWrite = 1'b1; end
      SLui:      begin e.aluSrcA = 2'b11; e.aluSrcB = 2'b01; end
      SFpExec:   begin e.aluOp = 2'b11; e.fpuStart = first; end
      SFpWb:     begin e.resultSrc = 2'b11; e.fRegWrite = 1'b1; end
      default:   e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] immFor(input logic [6:0] o);
    if (o == OpSw || o == OpFsw) return 3'b001;
    if (o == OpBq) return 3'b010;
    if (o == OpJl) return 3'b011;
    if (o == OpLu) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit isLegal(input logic [6:0] o);
    return o inside {OpLw, OpFlw, OpSw, OpFsw, OpR, OpI, OpBq, OpJl, OpJr, OpLu, OpF};
  endfunction

  function automatic outs_t expB();
    if (bCycle == 0) return expOut(SFetch, opB, memReady, 1'b0);
    if (bCycle == 1) return expOut(SDecode, opB, memReady, 1'b0);
    return expOut(SIllegal, opB, memReady, 1'b0);
  endfunction

  task automatic rnd();
    memReady = 1'($urandom_range(0, 1));
    fpuDone  = 1'($urandom_range(0, 1));
  endtask

  task automatic tick(input outs_t exp, input string tag);
    logic [CntW-1:0] wantRet;
    outs_t wantB;
    @(negedge clk);
    wantRet = CntW'(retired % (1 << CntW));
    checks++;
    assert (obsA === exp) else begin
      errors++; $error("FAIL %s strobes: got %h want %h", tag, obsA, exp);
    end
    checks++;
    assert (aInstret === wantRet) else begin
      errors++; $error("FAIL %s instret: got %0d want %0d", tag, aInstret, wantRet);
    end
    checks++;
    assert (aImm === immFor(op)) else begin
      errors++; $error("FAIL %s ImmSrc: got %b want %b", tag, aImm, immFor(op));
    end
    if (bActive) begin
      wantB = expB();
      checks++;
      assert (obsB === wantB) else begin
        errors++; $error("FAIL %s noFp strobes: got %h want %h", tag, obsB, wantB);
      end
    end
    @(posedge clk);
    #1;
    bCycle++;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    rnd();
    @(posedge clk);
    #1;
    resetN  = 1'b1;
    retired = 0;
    bCycle  = 0;
  endtask

  // fw/mw: stall cycles at fetch/memory; fl: FPU latency, >= Timeout means never done.
  task automatic runInstr(input logic [6:0] o, input int fw, input int mw, input int fl);
    bit ld;
    op = o;
    ld = (o == OpLw || o == OpFlw);
    for (int i = 0; i <= fw; i++) begin
      memReady = (i == fw);
      fpuDone  = 1'($urandom_range(0, 1));
      tick(expOut(SFetch, o, memReady, 1'b0), "fetch");
    end
    rnd(); tick(expOut(SDecode, o, 1'b0, 1'b0), "decode");
    trapped = 1'b0;
    case (o)
      OpLw, OpFlw, OpSw, OpFsw: begin
        rnd(); tick(expOut(SMemAdr, o, 1'b0, 1'b0), "memadr");
        for (int i = 0; i <= mw; i++) begin
          memReady = (i == mw);
          fpuDone  = 1'($urandom_range(0, 1));
          tick(expOut(ld ? SMemRead : SMemWrite, o, 1'b0, 1'b0), "memwait");
        end
        if (ld) begin rnd(); tick(expOut(SMemWb, o, 1'b0, 1'b0), "memwb"); end
      end
      OpR:  begin rnd(); tick(expOut(SExecR, o, 0, 0), "execr");
                  rnd(); tick(expOut(SAluWb, o, 0, 0), "aluwb"); end
      OpI:  begin rnd(); tick(expOut(SExecI, o, 0, 0), "execi");
                  rnd(); tick(expOut(SAluWb, o, 0, 0), "aluwb"); end
      OpBq: begin rnd(); tick(expOut(SBeq, o, 0, 0), "beq"); end
      OpJl: begin rnd(); tick(expOut(SJal, o, 0, 0), "jal");
                  rnd(); tick(expOut(SAluWb, o, 0, 0), "aluwb"); end
      OpJr: begin rnd(); tick(expOut(SJalrJ, o, 0, 0), "jalrj");
                  rnd(); tick(expOut(SJalrLnk, o, 0, 0), "jalrlnk"); end
      OpLu: begin rnd(); tick(expOut(SLui, o, 0, 0), "lui");
                  rnd(); tick(expOut(SAluWb, o, 0, 0), "aluwb"); end
      OpF: begin
        for (int i = 0; i < ((fl >= Timeout) ? Timeout : fl); i++) begin
          memReady = 1'($urandom_range(0, 1));
          fpuDone  = 1'b0;
          tick(expOut(SFpExec, o, 0, (i == 0)), "fpwait");
        end
        if (fl < Timeout) begin
          fpuDone = 1'b1;
          tick(expOut(SFpExec, o, 0, (fl == 0)), "fpdone");
          rnd(); tick(expOut(SFpWb, o, 0, 0), "fpwb");
        end else begin
          trapped = 1'b1;
        end
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      for (int i = 0; i < 3; i++) begin
        rnd();
        op = 7'($urandom);
        tick(expOut(SIllegal, op, 0, 0), "illegal");
      end
    end else begin
      retired++;
    end
  endtask

  initial begin
    logic [6:0] legalOps [11];
    logic [6:0] o;
    legalOps = '{OpLw, OpFlw, OpSw, OpFsw, OpR, OpI, OpBq, OpJl, OpJr, OpLu, OpF};
    resetN = 1'b0; memReady = 1'b0; fpuDone = 1'b0; op = OpR; opB = OpR;
    doReset();

    runInstr(OpR, 0, 0, 0);
    runInstr(OpLw, 0, 3, 0);
    runInstr(OpF, 0, 0, 5);
    runInstr(OpF, 1, 0, 0);
    runInstr(OpF, 0, 0, Timeout - 1);
    runInstr(OpF, 0, 0, Timeout);
    doReset();
    runInstr(OpSw, 2, 2, 0);

    // FP disabled: flw traps from decode in the second instance.
    doReset();
    opB = OpFlw;
    bActive = 1'b1;
    runInstr(OpFlw, 0, 0, 0);
    bActive = 1'b0;

    doReset();
    for (int i = 0; i < 16; i++) runInstr(OpBq, 0, 0, 0);
    memReady = 1'b0;
    @(negedge clk);
    checks++;
    assert (aInstret === 4'd0) else begin
      errors++; $error("FAIL wrap instret: got %0d want 0", aInstret);
    end
    @(posedge clk);
    #1;

    // Reset mid-jalr, mid-memory-wait and mid-FPU-wait.
    op = OpJr; memReady = 1'b1; fpuDone = 1'b0;
    tick(expOut(SFetch, op, 1'b1, 1'b0), "fetch");
    rnd(); tick(expOut(SDecode, op, 0, 0), "decode");
    rnd(); resetN = 1'b0; tick(expOut(SJalrJ, op, 0, 0), "jalrj-rst");
    resetN = 1'b1; retired = 0;
    runInstr(OpI, 0, 0, 0);
    op = OpLw; memReady = 1'b1;
    tick(expOut(SFetch, op, 1'b1, 1'b0), "fetch");
    rnd(); tick(expOut(SDecode, op, 0, 0), "decode");
    rnd(); tick(expOut(SMemAdr, op, 0, 0), "memadr");
    memReady = 1'b0; tick(expOut(SMemRead, op, 0, 0), "memread");
    resetN = 1'b0; tick(expOut(SMemRead, op, 0, 0), "memread-rst");
    resetN = 1'b1; retired = 0;
    runInstr(OpJl, 0, 0, 0);
    op = OpF; memReady = 1'b1; fpuDone = 1'b0;
    tick(expOut(SFetch, op, 1'b1, 1'b0), "fetch");
    fpuDone = 1'b0; tick(expOut(SDecode, op, 0, 0), "decode");
    tick(expOut(SFpExec, op, 0, 1'b1), "fpexec");
    resetN = 1'b0; tick(expOut(SFpExec, op, 0, 1'b0), "fpexec-rst");
    resetN = 1'b1; retired = 0;
    runInstr(OpF, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        do o = 7'($urandom); while (isLegal(o));
      end else begin
        o = legalOps[$urandom_range(0, 10)];
      end
      runInstr(o, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? int'(Timeout) : int'($urandom_range(0, Timeout - 1)));
      if (trapped) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control unit for the RV32I+F datapath and the successor to the single-cycle main decoder.
- Sequences each instruction through a Moore FSM over a shared ALU/memory datapath.
- Stalls on a memory ready handshake and on a variable-latency FPU start/done handshake, with an FPU timeout.
- Flags unsupported opcodes with a sticky trap.
- Counts retired instructions.
- Sits between the instruction register and the datapath muxes; aludec still consumes ALUOp.

## Interface
- FP_EN, 1: F-extension opcodes (0000111, 0100111, 1010011) legal when 1; treated as illegal when 0.
- FP_TIMEOUT, 64: max cycles spent waiting for fpu_done, ≥1.
- CNT_W, 32: width of retired-instruction counter.

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- op  in  7  opcode from instruction register; stable from the cycle after IRWrite
- mem_ready  in  1  memory access completes this cycle
- fpu_done  in  1  FPU result valid (sampled in FPEXEC only)
- PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite, FRegWrite  out  1 each  datapath strobes
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 FPU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 FP
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op
- fpu_start  out  1  one-cycle pulse on FPEXEC entry
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired instruction count

## Operation
- Unlisted outputs are 0 in each state. AdrSrc=1 only in MEMREAD/MEMWRITE.
- FETCH: ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCUpdate = mem_ready.
  - Hold while !mem_ready; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01 (branch/JAL target into ALUOut). Dispatch on op:
  - lw/sw/flw/fsw → MEMADR
  - R-type → EXECUTER
  - I-ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - jalr → JALRJ
  - lui → LUI
  - 1010011 → FPEXEC
  - anything else → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01. Loads → MEMREAD; stores → MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01. RegWrite for lw, FRegWrite for flw. → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Hold until mem_ready, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 → ALUWB.
- JALRJ: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCUpdate=1 → JALRLNK.
- JALRLNK: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1 → FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01 → ALUWB.
- FPEXEC: ALUOp=11; fpu_start=1 only on the entry cycle.
  - Wait counter cleared on entry, +1 per cycle.
  - fpu_done → FPWB.
  - Counter reaching FP_TIMEOUT without fpu_done → ILLEGAL.
- FPWB: ResultSrc=11, FRegWrite=1 → FETCH.
- ILLEGAL: illegal=1, all strobes 0. Absorbing state; only reset exits.
- instret: +1 on every transition into FETCH from a non-FETCH state; wraps modulo 2^CNT_W.

## Timing
- Reset (reset_n=0 at clk edge): state=FETCH, instret=0, illegal=0, wait counter=0. Reset overrides every state, including mid-FPEXEC and mid-memory-wait.
- Latency with mem_ready tied high: R/I/lui 4 cycles, beq 3, jal 4, jalr 4, lw/flw 5, sw/fsw 4, FP 4 + FPU latency.
- fpu_done in the same cycle as the entry pulse is accepted, giving 1-cycle FPEXEC.
- fpu_done and timeout in the same cycle: fpu_done wins.
- fpu_done outside FPEXEC is ignored.
- Memory waits are unbounded.
- Outputs are Moore, except IRWrite/PCUpdate in FETCH (gated by mem_ready) and ImmSrc (a function of op).

## Structure
- mc_ctrl_pkg: opcode constants, state enum, ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
- Sub-module imm_src_dec: combinational op → ImmSrc.
- FSM, wait counter and instret counter live in multicycle_ctrl.

## Test plan
- Reset then add (0110011), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB; RegWrite high in cycle 4; instret=1.
- lw with mem_ready low 3 cycles in MEMREAD → AdrSrc held high; MEMWB reached 3 cycles late; RegWrite=1, ResultSrc=01.
- FP op, fpu_done after 5 cycles → single fpu_start pulse; FPWB with FRegWrite=1, ResultSrc=11; RegWrite never asserted.
- FP op, FP_TIMEOUT=8, fpu_done never → illegal=1 after 8 FPEXEC cycles and stays high; reset_n=0 clears it, FSM returns to FETCH.
- FP_EN=0, flw opcode → ILLEGAL from DECODE; no MemWrite/RegWrite pulses.
- CNT_W=4, 16 beq instructions → instret wraps to 0; reset_n low during JALRJ → FETCH next cycle, instret=0.
